lstm_step_sched: RTL and testbench
==================================

# lstm_step_sched

Sequencer for the LSTM systolic-array pass. It drives the cyclic address generator once per gate (i, f, g, o) for every timestep, and waits out the array's pipeline drain after each gate. After all four gates of a timestep it hands off to the cell/hidden-state update unit, then repeats for the programmed number of timesteps. It sits between the host/top-level control and the address generator plus element-wise update unit.

## Interface
Parameters:
- STEP_BITS, 8, width of timestep count and index
- DRAIN_CYC, 3, idle cycles after each gate for array drain; legal range 1..15

Ports:
- sys_clk  in  1  systolic array clock
- reset  in  1  synchronous, active-high reset
- go  in  1  start request; accepted only in IDLE
- num_steps  in  STEP_BITS  timesteps to process; sampled on accepted go
- abort  in  1  synchronous cancel; returns to IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- ag_start  out  1  held high while the address generator runs a gate
- ag_done  in  1  address generator finished current gate
- gate_sel  out  2  current gate: 0=i, 1=f, 2=g, 3=o
- step_idx  out  STEP_BITS  current timestep index
- cell_upd  out  1  one-cycle pulse requesting the c/h update
- cell_ack  in  1  update unit finished

## Operation
- States: IDLE, RUN, DRAIN, UPD, WAIT, FIN.
- IDLE:
  - go=1 with num_steps≠0: latch num_steps, gate_sel←0, step_idx←0, go to RUN.
  - go=1 with num_steps=0: go to FIN.
- RUN: ag_start=1. ag_done=1 moves to DRAIN and loads the drain counter with DRAIN_CYC-1.
- DRAIN: ag_start=0; lasts exactly DRAIN_CYC cycles. This also guarantees at least one start-low cycle, so the generator resets its address. Exit:
  - gate_sel<3: gate_sel+1, go to RUN.
  - gate_sel=3: go to UPD.
- UPD: cell_upd=1 for this single cycle, then WAIT.
- WAIT: on cell_ack=1:
  - step_idx=latched-1: go to FIN.
  - otherwise: step_idx+1, gate_sel←0, go to RUN.
- FIN: done=1 for one cycle, then IDLE.
- All outputs are registered. step_idx never wraps, because the compare happens before the increment.

## Timing
- Reset values: state IDLE, busy=0, done=0, ag_start=0, cell_upd=0, gate_sel=0, step_idx=0.
- Latency:
  - go in cycle c → state RUN and ag_start=1 in c+1.
  - ag_done in cycle c → ag_start=0 in c+1.
- Per gate: (RUN cycles up to and including the ag_done cycle) + DRAIN_CYC.
- Ignored inputs:
  - ag_done outside RUN.
  - cell_ack outside WAIT, including the UPD cycle.
  - go when not in IDLE.
- abort has priority over every transition. Any abort cycle → IDLE next cycle, all outputs at reset values, no done pulse. abort in IDLE has no effect.
- reset mid-operation behaves identically to abort.
- abort and go in the same cycle: abort wins, go is dropped.

## Structure
- Shared package lstm_ctrl_pkg holds:
  - state enum type (sched_state_t)
  - gate encodings GATE_I/F/G/O
  - NUM_GATES=4
- Single flat module; the drain counter (4 bits) is inline. No sub-module is warranted.

## Test plan
- Timed run: num_steps=1, DRAIN_CYC=3, ag_done on the 10th RUN cycle of each gate, cell_ack the cycle after cell_upd, go at c0.
  - ag_start high c1–c10; gate_sel 1 at c14, 3 by c40.
  - cell_upd at c53, done at c55, busy low at c56.
- Zero steps: num_steps=0, go at c0 → done at c1, ag_start never asserted, busy low at c2.
- Multi-step: num_steps=3 → step_idx sequence 0,1,2, twelve ag_start pulses, three cell_upd pulses, one done pulse.
- Ignored inputs:
  - go pulsed mid-RUN → no restart, counters unchanged.
  - ag_done in DRAIN → ignored.
  - cell_ack held high during UPD → not consumed until WAIT.
- Abort: during DRAIN of gate 2, step 1 → next cycle IDLE, gate_sel=0, step_idx=0, no done pulse; a fresh go then runs normally.
- Reset: asserted in WAIT → all outputs at reset values next cycle; the late cell_ack is ignored.

Source files
------------

// File: rtl/lstm_ctrl_pkg.sv
// Shared control types for the LSTM step sequencer.
// Scheduler state encoding and gate order.
package lstm_ctrl_pkg;

  localparam int NUM_GATES = 4;

  localparam logic [1:0] GATE_I = 2'd0;
  localparam logic [1:0] GATE_F = 2'd1;
  localparam logic [1:0] GATE_G = 2'd2;
  localparam logic [1:0] GATE_O = 2'(NUM_GATES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    UPD,
    WAIT,
    FIN
  } sched_state_t;

endpackage

// File: rtl/lstm_step_sched.sv
// LSTM timestep sequencer: four gate passes, drain, then c/h update.
// Outputs are registered from the next-state decode.
module lstm_step_sched
  import lstm_ctrl_pkg::*;
#(
  parameter int STEP_BITS = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [STEP_BITS-1:0] num_steps,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 ag_start,
  input  logic                 ag_done,
  output logic [1:0]           gate_sel,
  output logic [STEP_BITS-1:0] step_idx,
  output logic                 cell_upd,
  input  logic                 cell_ack
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);
  localparam logic [STEP_BITS-1:0] ONE = STEP_BITS'(1);

  sched_state_t         state_q;
  sched_state_t         state_d;
  logic [3:0]           cnt_q;
  logic [3:0]           cnt_d;
  logic [STEP_BITS-1:0] nsteps_q;
  logic [STEP_BITS-1:0] nsteps_d;
  logic [STEP_BITS-1:0] step_d;
  logic [1:0]           gate_d;
  logic                 last_step;

  // Compare before increment so step_idx never wraps.
  assign last_step = (step_idx == nsteps_q - ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nsteps_d = nsteps_q;
    gate_d   = gate_sel;
    step_d   = step_idx;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          if (num_steps != '0) begin
            nsteps_d = num_steps;
            gate_d   = GATE_I;
            step_d   = '0;
            state_d  = RUN;
          end else begin
            state_d  = FIN;
          end
        end
      end
      RUN: begin
        if (ag_done) begin
          cnt_d   = DRAIN_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) begin
          if (gate_sel == GATE_O) begin
            state_d = UPD;
          end else begin
            gate_d  = gate_sel + 2'd1;
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      UPD: state_d = WAIT;
      WAIT: begin
        if (cell_ack) begin
          if (last_step) begin
            state_d = FIN;
          end else begin
            step_d  = step_idx + ONE;
            gate_d  = GATE_I;
            state_d = RUN;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Cancel wins over everything; idle state is left untouched.
    if (abort) begin
      state_d  = IDLE;
      cnt_d    = cnt_q;
      nsteps_d = nsteps_q;
      gate_d   = (state_q == IDLE) ? gate_sel : GATE_I;
      step_d   = (state_q == IDLE) ? step_idx : '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      nsteps_q <= '0;
      gate_sel <= GATE_I;
      step_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ag_start <= 1'b0;
      cell_upd <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nsteps_q <= nsteps_d;
      gate_sel <= gate_d;
      step_idx <= step_d;
      busy     <= (state_d != IDLE);
      done     <= (state_d == FIN);
      ag_start <= (state_d == RUN);
      cell_upd <= (state_d == UPD);
    end
  end

endmodule

// File: tb/tb_lstm_step_sched.sv
// Bench for lstm_step_sched: procedural reference model,
// directed timing pins and randomized traffic.
module tb_lstm_step_sched;

  localparam int SB    = 8;
  localparam int DRAIN = 3;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [SB-1:0] num_steps = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          ag_start;
  logic          ag_done = 1'b0;
  logic [1:0]    gate_sel;
  logic [SB-1:0] step_idx;
  logic          cell_upd;
  logic          cell_ack = 1'b0;

  always #5 sys_clk = ~sys_clk;

  lstm_step_sched #(.STEP_BITS(SB), .DRAIN_CYC(DRAIN)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .go        (go),
    .num_steps (num_steps),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .ag_start  (ag_start),
    .ag_done   (ag_done),
    .gate_sel  (gate_sel),
    .step_idx  (step_idx),
    .cell_upd  (cell_upd),
    .cell_ack  (cell_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            armed = 0;
  bit            kill;
  bit            m_rst, m_ab, m_go, m_agd, m_ack;
  logic [SB-1:0] m_ns;
  int            m_n;
  logic          e_busy, e_done, e_ags, e_upd;
  logic [1:0]    e_gate;
  logic [SB-1:0] e_step;

  task automatic adv();
    @(posedge sys_clk);
    m_rst = reset;
    m_ab  = reset | abort;
    m_go  = go;
    m_ns  = num_steps;
    m_agd = ag_done;
    m_ack = cell_ack;
    if (m_rst) armed = 1;
  endtask

  task automatic set_o(bit b, bit d, bit a, bit u);
    e_busy = b; e_done = d; e_ags = a; e_upd = u;
  endtask

  task automatic kill_now();
    kill = 1;
    set_o(0, 0, 0, 0);
    e_gate = 0;
    e_step = 0;
  endtask

  initial begin : model
    set_o(0, 0, 0, 0);
    e_gate = 0;
    e_step = 0;
    forever begin
      adv();
      if (m_rst) begin
        kill_now();
      end else if (!m_ab && m_go) begin
        kill = 0;
        if (m_ns == 0) begin
          set_o(1, 1, 0, 0);
        end else begin
          m_n = int'(m_ns);
          for (int s = 0; s < m_n && !kill; s++) begin
            e_step = SB'(s);
            for (int g = 0; g < 4 && !kill; g++) begin
              e_gate = 2'(g);
              set_o(1, 0, 1, 0);
              do begin
                adv();
                if (m_ab) kill_now();
              end while (!kill && !m_agd);
              if (!kill) begin
                set_o(1, 0, 0, 0);
                for (int d = 0; d < DRAIN && !kill; d++) begin
                  adv();
                  if (m_ab) kill_now();
                end
              end
            end
            if (!kill) begin
              set_o(1, 0, 0, 1);
              adv();
              if (m_ab) kill_now();
            end
            if (!kill) begin
              set_o(1, 0, 0, 0);
              do begin
                adv();
                if (m_ab) kill_now();
              end while (!kill && !m_ack);
            end
          end
          if (!kill) set_o(1, 1, 0, 0);
        end
        if (!kill) begin
          adv();
          if (m_ab) kill_now();
          else set_o(0, 0, 0, 0);
        end
      end
    end
  end

  always begin
    @(posedge sys_clk);
    #1;
    if (armed)
      chk("outputs",
          {busy, done, ag_start, cell_upd, gate_sel, step_idx},
          {e_busy, e_done, e_ags, e_upd, e_gate, e_step});
  end

  // ---------------- responder for ag_done / cell_ack ----------------
  int rmode = 0;
  int agd_at = 10;
  int run_cnt = 0;
  bit hold2 = 0, ack_hold = 0, agd_prev = 0, upd_prev = 0, man_ack = 0;

  always begin
    @(posedge sys_clk);
    #2;
    run_cnt = ag_start ? run_cnt + 1 : 0;
    if (rmode == 0) begin
      ag_done  = ($urandom_range(0, 2) == 0);
      cell_ack = ($urandom_range(0, 2) == 0);
    end else begin
      ag_done = (ag_start && run_cnt == agd_at) || (hold2 && agd_prev);
      if (rmode == 2) cell_ack = man_ack;
      else cell_ack = ack_hold || upd_prev;
    end
    agd_prev = ag_start && run_cnt == agd_at;
    upd_prev = cell_upd;
  end

  task automatic cw();
    @(posedge sys_clk);
    #2;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    int ags_first, ags_end, g1_first, g3_first;
    int upd_k, done_k, bl_k, m_upd_k, m_done_k;
    int pulses, upds, dones, fin, hit, cnt;
    bit prev;

    repeat (3) cw();
    reset = 0;
    cw();
    chk("reset_state",
        {busy, done, ag_start, cell_upd, gate_sel, step_idx}, 0);

    // Timed single-step run
    rmode = 1; agd_at = 10; hold2 = 0; ack_hold = 0;
    go = 1; num_steps = 1;
    ags_first = -1; ags_end = -1; g1_first = -1; g3_first = -1;
    upd_k = -1; done_k = -1; bl_k = -1; m_upd_k = -1; m_done_k = -1;
    for (int k = 1; k <= 60; k++) begin
      cw();
      if (k == 1) go = 0;
      if (ag_start && ags_first < 0) ags_first = k;
      if (ags_first >= 0 && !ag_start && ags_end < 0) ags_end = k - 1;
      if (busy && gate_sel == 1 && g1_first < 0) g1_first = k;
      if (busy && gate_sel == 3 && g3_first < 0) g3_first = k;
      if (cell_upd && upd_k < 0) upd_k = k;
      if (done && done_k < 0) done_k = k;
      if (done_k >= 0 && !busy && bl_k < 0) bl_k = k;
      if (e_upd && m_upd_k < 0) m_upd_k = k;
      if (e_done && m_done_k < 0) m_done_k = k;
    end
    chk("t_ags_first", ags_first, 1);
    chk("t_ags_end", ags_end, 10);
    chk("t_gate1", g1_first, 14);
    chk("t_gate3", g3_first, 40);
    chk("t_cell_upd", upd_k, 53);
    chk("t_done", done_k, 55);
    chk("t_busy_low", bl_k, 56);
    chk("t_model_upd", m_upd_k, 53);
    chk("t_model_done", m_done_k, 55);

    // Zero steps
    cw();
    go = 1; num_steps = 0;
    cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      cw();
      if (k == 1) begin
        go = 0;
        chk("z_done_c1", done, 1);
      end
      if (k == 2) chk("z_busy_c2", busy, 0);
      if (ag_start) cnt++;
    end
    chk("z_no_ag_start", cnt, 0);

    // Multi-step with ignored go / ag_done / held cell_ack
    rmode = 1; agd_at = 4; hold2 = 1; ack_hold = 1;
    cw();
    go = 1; num_steps = 3;
    pulses = 0; upds = 0; dones = 0; fin = 0; prev = 0;
    for (int k = 1; k <= 400 && fin == 0; k++) begin
      cw();
      go = (k == 3);
      if (k == 3) num_steps = 7;
      if (ag_start && !prev) begin
        chk("ms_step", step_idx, pulses / 4);
        chk("ms_gate", gate_sel, pulses % 4);
        pulses++;
      end
      prev = ag_start;
      if (cell_upd) upds++;
      if (done) dones++;
      if (!busy) fin = 1;
    end
    go = 0;
    chk("ms_finished", fin, 1);
    chk("ms_ag_pulses", pulses, 12);
    chk("ms_upd_pulses", upds, 3);
    chk("ms_done_pulses", dones, 1);

    // Abort in DRAIN of gate 2, step 1
    rmode = 1; agd_at = 3; hold2 = 0; ack_hold = 0;
    cw();
    go = 1; num_steps = 3;
    hit = 0;
    for (int k = 1; k <= 300; k++) begin
      cw();
      go = 0;
      if (busy && !ag_start && !cell_upd &&
          gate_sel == 2 && step_idx == 1) begin
        hit = 1;
        break;
      end
    end
    chk("ab_reach_drain", hit, 1);
    abort = 1;
    cw();
    abort = 0;
    chk("ab_idle",
        {busy, done, ag_start, cell_upd, gate_sel, step_idx}, 0);
    cnt = 0;
    repeat (5) begin
      cw();
      if (done) cnt++;
    end
    chk("ab_no_done", cnt, 0);
    go = 1; num_steps = 1;
    hit = 0;
    for (int k = 1; k <= 200; k++) begin
      cw();
      go = 0;
      if (done) begin
        hit = 1;
        break;
      end
    end
    chk("ab_rerun_done", hit, 1);

    // Reset while waiting for cell_ack
    rmode = 2; agd_at = 2; man_ack = 0;
    repeat (2) cw();
    go = 1; num_steps = 2;
    hit = 0;
    for (int k = 1; k <= 200; k++) begin
      cw();
      go = 0;
      if (cell_upd) begin
        hit = 1;
        break;
      end
    end
    chk("rw_reach_upd", hit, 1);
    cw();
    reset = 1;
    cw();
    reset = 0;
    man_ack = 1;
    chk("rw_reset_state",
        {busy, done, ag_start, cell_upd, gate_sel, step_idx}, 0);
    cnt = 0;
    repeat (5) begin
      cw();
      if (done || busy) cnt++;
    end
    man_ack = 0;
    chk("rw_late_ack_ignored", cnt, 0);

    // Randomized traffic against the model
    rmode = 0;
    repeat (4000) begin
      cw();
      go = ($urandom_range(0, 5) == 0);
      num_steps = SB'($urandom_range(0, 3));
      abort = ($urandom_range(0, 80) == 0);
      reset = ($urandom_range(0, 300) == 0);
    end
    go = 0; abort = 0; reset = 0;
    repeat (3) cw();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
